// File: rtl/iob_mtimer_if.sv
// IOb request/response bundle between an initiator (master) and the machine timer (slave).
// ready is held high by the responder; a request is accepted on any edge where avalid & ready.
interface iob_mtimer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  rvalid, rdata, ready
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output rvalid, rdata, ready
    );
endinterface

// File: rtl/iob_mtimer.sv
// Single-hart RISC-V machine timer (mtime/mtimecmp/mtip) behind an IOb responder port.
// Optional IOB_MTIMER_SNAPSHOT_EN: reading MTIME_LO latches mtime[63:32] for a tear-free MTIME_HI read.
module iob_mtimer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        rtc_i,
    iob_mtimer_if.slave iob,
    output logic        mtip_o
);
    localparam logic [2:0] REG_CMP_LO  = 3'd0;
    localparam logic [2:0] REG_CMP_HI  = 3'd1;
    localparam logic [2:0] REG_TIME_LO = 3'd2;
    localparam logic [2:0] REG_TIME_HI = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;

    logic [63:0]       mtime, mtime_nxt;
    logic [63:0]       mtimecmp, mtimecmp_nxt;
    logic              en, en_nxt;
    logic              ready, rvalid, mtip;
    logic [DATA_W-1:0] rdata, rd_mux;
    logic              rtc_s1, rtc_s2, rtc_s3, tick;
    logic [2:0]        sel;
    logic              acc, rd_acc, wr_acc;
    logic              unused_addr;

    assign sel         = iob.addr[4:2];
    assign unused_addr = ^iob.addr[1:0];
    assign acc         = iob.avalid & ready;
    assign rd_acc      = acc & (iob.wstrb == '0);
    assign wr_acc      = acc & (iob.wstrb != '0);
    assign tick        = rtc_s2 & ~rtc_s3;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] wd,
                                                input logic [DATA_W/8-1:0] strb);
        merge = old;
        for (int i = 0; i < DATA_W/8; i++) begin
            if (strb[i]) merge[8*i +: 8] = wd[8*i +: 8];
        end
    endfunction

`ifdef IOB_MTIMER_SNAPSHOT_EN
    logic [31:0] shadow;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shadow <= '0;
        end else if (rd_acc && sel == REG_TIME_LO) begin
            shadow <= mtime[63:32];
        end
    end
`endif

    // A bus write to either mtime half replaces the whole increment for that cycle.
    always_comb begin
        mtime_nxt    = (tick & en) ? mtime + 64'd1 : mtime;
        mtimecmp_nxt = mtimecmp;
        en_nxt       = en;
        if (wr_acc) begin
            case (sel)
                REG_CMP_LO:  mtimecmp_nxt[31:0]  = merge(mtimecmp[31:0], iob.wdata, iob.wstrb);
                REG_CMP_HI:  mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], iob.wdata, iob.wstrb);
                REG_TIME_LO: mtime_nxt = {mtime[63:32], merge(mtime[31:0], iob.wdata, iob.wstrb)};
                REG_TIME_HI: mtime_nxt = {merge(mtime[63:32], iob.wdata, iob.wstrb), mtime[31:0]};
                REG_CTRL:    if (iob.wstrb[0]) en_nxt = iob.wdata[0];
                default:     ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_CMP_LO:  rd_mux = mtimecmp[31:0];
            REG_CMP_HI:  rd_mux = mtimecmp[63:32];
            REG_TIME_LO: rd_mux = mtime[31:0];
`ifdef IOB_MTIMER_SNAPSHOT_EN
            REG_TIME_HI: rd_mux = shadow;
`else
            REG_TIME_HI: rd_mux = mtime[63:32];
`endif
            REG_CTRL:    rd_mux = {{(DATA_W-1){1'b0}}, en};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b1;
            mtip     <= 1'b0;
            ready    <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rtc_s1   <= 1'b0;
            rtc_s2   <= 1'b0;
            rtc_s3   <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            en       <= en_nxt;
            mtip     <= (mtime >= mtimecmp);
            ready    <= 1'b1;
            rvalid   <= rd_acc;
            if (rd_acc) rdata <= rd_mux;
            rtc_s1   <= rtc_i;
            rtc_s2   <= rtc_s1;
            rtc_s3   <= rtc_s2;
        end
    end

    assign iob.ready  = ready;
    assign iob.rvalid = rvalid;
    assign iob.rdata  = rdata;
    assign mtip_o     = mtip;
endmodule

// File: tb/tb_iob_mtimer.sv
// Self-checking bench for iob_mtimer: directed timer scenarios plus randomized register traffic
// compared against a plain 64-bit behavioural model of the timer.
module tb_iob_mtimer;
    logic clk = 1'b0;
    logic arst = 1'b1;
    logic rtc = 1'b0;
    logic mtip;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [31:0] m_shadow;

    iob_mtimer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    iob_mtimer #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .rtc_i  (rtc),
        .iob    (bus),
        .mtip_o (mtip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en     = 1'b1;
        m_shadow = 32'd0;
    endtask

    function automatic logic [31:0] strobe_merge(input logic [31:0] old, input logic [31:0] d,
                                                 input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] r);
        case (r)
            3'd0: return m_cmp[31:0];
            3'd1: return m_cmp[63:32];
            3'd2: return m_mtime[31:0];
`ifdef IOB_MTIMER_SNAPSHOT_EN
            3'd3: return m_shadow;
`else
            3'd3: return m_mtime[63:32];
`endif
            3'd4: return {31'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
        case (r)
            3'd0: m_cmp[31:0]    = strobe_merge(m_cmp[31:0], d, s);
            3'd1: m_cmp[63:32]   = strobe_merge(m_cmp[63:32], d, s);
            3'd2: m_mtime[31:0]  = strobe_merge(m_mtime[31:0], d, s);
            3'd3: m_mtime[63:32] = strobe_merge(m_mtime[63:32], d, s);
            3'd4: if (s[0]) m_en = d[0];
            default: ;
        endcase
    endtask

    task automatic drive_req(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
        bus.avalid = 1'b1;
        bus.addr   = {r, 2'b00};
        bus.wdata  = d;
        bus.wstrb  = s;
    endtask

    task automatic drive_idle();
        bus.avalid = 1'b0;
        bus.wstrb  = 4'd0;
    endtask

    task automatic bus_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        drive_req(r, d, s);
        @(negedge clk);
        drive_idle();
        model_write(r, d, s);
        check("wr_no_rvalid", {63'd0, bus.rvalid}, 64'd0);
    endtask

    task automatic bus_read(input logic [2:0] r, output logic [31:0] data);
        logic [31:0] exp;
        exp = exp_read(r);
        if (r == 3'd2) m_shadow = m_mtime[63:32];
        @(negedge clk);
        drive_req(r, $urandom, 4'd0);
        @(negedge clk);
        drive_idle();
        data = bus.rdata;
        check("rd_rvalid", {63'd0, bus.rvalid}, 64'd1);
        check($sformatf("rd_data_r%0d", r), {32'd0, data}, {32'd0, exp});
        @(negedge clk);
        check("rd_rvalid_drop", {63'd0, bus.rvalid}, 64'd0);
        check("rd_data_hold", {32'd0, bus.rdata}, {32'd0, exp});
    endtask

    task automatic rtc_pulse();
        @(negedge clk);
        rtc = 1'b1;
        repeat (4) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        if (m_en) m_mtime = m_mtime + 64'd1;
    endtask

    task automatic check_mtip(input string tag);
        @(negedge clk);
        check(tag, {63'd0, mtip}, {63'd0, (m_mtime >= m_cmp)});
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 20));
            1: return 32'hFFFF_FFFF;
            2: return $urandom;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        drive_idle();
        bus.addr  = '0;
        bus.wdata = '0;
        model_reset();

        // reset held for 100 cycles
        repeat (100) @(negedge clk);
        check("rst_ready",  {63'd0, bus.ready},  64'd0);
        check("rst_mtip",   {63'd0, mtip},       64'd0);
        check("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("rst_rdata",  {32'd0, bus.rdata},  64'd0);
        arst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {63'd0, bus.ready}, 64'd1);
        bus_read(3'd1, rd);
        check("rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        bus_read(3'd2, rd);
        check("rst_time_lo", {32'd0, rd}, 64'd0);
        bus_read(3'd4, rd);

        // counting and freezing
        repeat (10) rtc_pulse();
        bus_read(3'd2, rd);
        check("count10", {32'd0, rd}, 64'd10);
        bus_write(3'd4, 32'd0, 4'hF);
        repeat (5) rtc_pulse();
        bus_read(3'd2, rd);
        check("frozen", {32'd0, rd}, 64'd10);
        bus_write(3'd4, 32'd1, 4'hF);

        // interrupt timing: mtime reaches 200 three cycles after the rtc edge, mtip one later
        bus_write(3'd0, 32'd200, 4'hF);
        bus_write(3'd1, 32'd0, 4'hF);
        bus_write(3'd3, 32'd0, 4'hF);
        bus_write(3'd2, 32'd199, 4'hF);
        check_mtip("mtip_below");
        @(negedge clk);
        rtc = 1'b1;
        repeat (3) @(negedge clk);
        check("mtip_lag", {63'd0, mtip}, 64'd0);
        @(negedge clk);
        check("mtip_rise", {63'd0, mtip}, 64'd1);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        m_mtime = 64'd200;
        bus_write(3'd2, 32'd0, 4'hF);
        check("mtip_hold", {63'd0, mtip}, 64'd1);
        @(negedge clk);
        check("mtip_fall", {63'd0, mtip}, 64'd0);

        // wrap
        bus_write(3'd2, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd3, 32'hFFFF_FFFF, 4'hF);
        check_mtip("mtip_at_max");
        rtc_pulse();
        bus_read(3'd2, rd);
        bus_read(3'd3, rd2);
        check("wrap_value", {rd2, rd}, 64'd0);
        check_mtip("mtip_after_wrap");

        // byte strobes
        bus_write(3'd2, 32'h1234_5678, 4'b0011);
        bus_read(3'd2, rd);
        check("strobe_lo", {32'd0, rd}, 64'h0000_5678);

        // write aligned with a tick: the write wins, no increment
        @(negedge clk);
        rtc = 1'b1;
        repeat (2) @(negedge clk);
        drive_req(3'd2, 32'd50, 4'hF);
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        model_write(3'd2, 32'd50, 4'hF);
        bus_read(3'd2, rd);
        check("collision", {32'd0, rd}, 64'd50);

        // tear-free read
        bus_write(3'd2, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd3, 32'd1, 4'hF);
        bus_read(3'd2, rd);
        rtc_pulse();
        bus_read(3'd3, rd2);
`ifdef IOB_MTIMER_SNAPSHOT_EN
        check("snapshot_hi", {32'd0, rd2}, 64'd1);
`else
        check("live_hi", {32'd0, rd2}, 64'd2);
`endif

        // back-to-back reads
        @(negedge clk);
        drive_req(3'd0, 32'd0, 4'd0);
        @(negedge clk);
        drive_req(3'd4, 32'd0, 4'd0);
        check("b2b_rvalid0", {63'd0, bus.rvalid}, 64'd1);
        check("b2b_data0", {32'd0, bus.rdata}, {32'd0, exp_read(3'd0)});
        @(negedge clk);
        drive_idle();
        check("b2b_rvalid1", {63'd0, bus.rvalid}, 64'd1);
        check("b2b_data1", {32'd0, bus.rdata}, {32'd0, exp_read(3'd4)});

        // randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            int op;
            logic [2:0] r;
            op = $urandom_range(0, 9);
            r  = 3'($urandom_range(0, 7));
            if (op <= 3) begin
                bus_write(r, pick_data(), 4'($urandom_range(1, 15)));
            end else if (op <= 6) begin
                bus_read(r, rd);
            end else begin
                rtc_pulse();
            end
            check_mtip("rand_mtip");
        end

        // reset while a read response is pending
        bus_write(3'd0, 32'd7, 4'hF);
        @(negedge clk);
        drive_req(3'd0, 32'd0, 4'd0);
        @(negedge clk);
        drive_idle();
        arst = 1'b1;
        #1;
        check("midrst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        check("midrst_rdata",  {32'd0, bus.rdata},  64'd0);
        check("midrst_mtip",   {63'd0, mtip},       64'd0);
        model_reset();
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        bus_read(3'd0, rd);
        bus_read(3'd1, rd);
        bus_read(3'd2, rd);
        bus_read(3'd4, rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
